mix_column_engine: RTL

Sequential, parametrised MixColumns/InvMixColumns engine for the AES datapath. It accepts a 128-bit state over a valid/ready handshake and latches the direction per block. It transforms COLS_PER_CYCLE columns per clock and presents the result on a valid/ready output port. It sits between ShiftRows and AddRoundKey in the iterative round core, and it also serves the decryption path (InvMixColumns) without a second instance.

---
 rtl/mix_column_engine_if.sv | 20 ++
 rtl/mix_column_engine.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/mix_column_engine_if.sv
// Handshake bundle for the MixColumns engine: input state port and result port.
interface mix_column_engine_if;
    logic         in_valid;
    logic         in_ready;
    logic         in_inv;
    logic [127:0] in_state;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;

    modport master (
        output in_valid, in_inv, in_state, out_ready,
        input  in_ready, out_valid, out_state
    );

    modport slave (
        input  in_valid, in_inv, in_state, out_ready,
        output in_ready, out_valid, out_state
    );
endinterface

// File: rtl/mix_column_engine.sv
// Sequential MixColumns / InvMixColumns engine; COLS_PER_CYCLE columns per clock.
module mix_column_engine #(
    parameter int unsigned COLS_PER_CYCLE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    mix_column_engine_if.slave bus,
    output logic              busy
);

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
        $error("mix_column_engine: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    // idx is 2 bits and wraps back to 0 after the last column; with 4 columns
    // per cycle the step is 0 and the single CALC cycle is also the last one.
    localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST_IDX = 2'(4 - COLS_PER_CYCLE);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q, state_d;
    logic [3:0][31:0] work, work_next;   // work[3] is column 0 (MSB word)
    logic [1:0]       idx;
    logic             mode;
    logic             capture, step;
    logic             in_ready_c, out_valid_c, busy_c;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
        logic [7:0]  a  [4];
        logic [7:0]  x2 [4];
        logic [7:0]  x4 [4];
        logic [7:0]  x8 [4];
        logic [7:0]  m0 [4];
        logic [7:0]  m1 [4];
        logic [7:0]  m2 [4];
        logic [7:0]  m3 [4];
        logic [31:0] res;
        res = '0;
        for (int unsigned r = 0; r < 4; r++) begin
            a[r]  = col[31 - 8*r -: 8];
            x2[r] = xtime(a[r]);
            x4[r] = xtime(x2[r]);
            x8[r] = xtime(x4[r]);
            m0[r] = inv ? (x2[r] ^ x4[r] ^ x8[r]) : x2[r];
            m1[r] = inv ? (a[r] ^ x2[r] ^ x8[r])  : (x2[r] ^ a[r]);
            m2[r] = inv ? (a[r] ^ x4[r] ^ x8[r])  : a[r];
            m3[r] = inv ? (a[r] ^ x8[r])          : a[r];
        end
        for (int unsigned r = 0; r < 4; r++) begin
            res[31 - 8*r -: 8] = m0[r] ^ m1[(r + 1) % 4] ^ m2[(r + 2) % 4] ^ m3[(r + 3) % 4];
        end
        return res;
    endfunction

    // Transform the COLS_PER_CYCLE columns starting at idx.
    always_comb begin
        logic [1:0] col;
        col       = '0;
        work_next = work;
        for (int unsigned k = 0; k < COLS_PER_CYCLE; k++) begin
            col = idx + 2'(k);
            work_next[2'd3 - col] = mix_col(work[2'd3 - col], mode);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, handshake outputs and datapath controls.
    always_comb begin
        state_d     = state_q;
        capture     = 1'b0;
        step        = 1'b0;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        busy_c      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    capture = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                busy_c = 1'b1;
                step   = 1'b1;
                if (idx == LAST_IDX) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid_c = 1'b1;
                in_ready_c  = bus.out_ready;
                if (bus.out_ready) begin
                    if (bus.in_valid) begin
                        capture = 1'b1;
                        state_d = CALC;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Working register, direction and column index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work <= '0;
            mode <= 1'b0;
            idx  <= '0;
        end else if (capture) begin
            work <= bus.in_state;
            mode <= bus.in_inv;
            idx  <= '0;
        end else if (step) begin
            work <= work_next;
            idx  <= idx + STEP;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_state = work;
    assign busy          = busy_c;

endmodule
